seq_divider8x4: RTL

- Sequential restoring divider: the inverse operation of the combinational 4x4 multiplier.
- Takes an 8-bit dividend (the multiplier's product width) and a 4-bit divisor (the multiplier's operand width).
- Returns an 8-bit quotient and a 4-bit remainder, producing one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit; it is started by a start/done handshake.

---
 rtl/arith_pkg.sv | 17 +
 rtl/seq_divider8x4_div_step.sv | 24 ++
 rtl/seq_divider8x4.sv | 95 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: operand widths, divider FSM encoding
// and the divide-by-zero result constant.
package arith_pkg;

    localparam int unsigned N_W   = 8;
    localparam int unsigned D_W   = 4;
    localparam int unsigned CNT_W = $clog2(N_W + 1);

    localparam logic [N_W-1:0] DIV0_Q = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider8x4_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step
    import arith_pkg::*;
(
    input  logic [D_W:0]   rem_in,
    input  logic           dvd_msb,
    input  logic [D_W-1:0] divisor,
    output logic [D_W:0]   rem_out,
    output logic           q_bit
);

    logic [D_W+1:0] shifted;
    logic [D_W+1:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_msb};
        // Extra top bit serves as the borrow/sign of the trial subtraction.
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[D_W+1];
        rem_out = q_bit ? trial[D_W:0] : shifted[D_W:0];
    end

endmodule

// File: rtl/seq_divider8x4.sv
// Sequential 8/4 restoring divider, one quotient bit per clock, with a
// start/done handshake and divide-by-zero flag.
module seq_divider8x4
    import arith_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] R,
    input  logic [D_W-1:0] B,
    output logic [N_W-1:0] Q,
    output logic [D_W-1:0] Rem,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    div_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0] dvd;
    logic [D_W-1:0] dvs;
    logic [D_W:0]   prem;
    logic [D_W:0]   prem_next;
    logic           q_bit;

    div_step u_step (
        .rem_in  (prem),
        .dvd_msb (dvd[N_W-1]),
        .divisor (dvs),
        .rem_out (prem_next),
        .q_bit   (q_bit)
    );

    // Quotient bits shift into the low end of the dividend register as its
    // high bits are consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            prem     <= '0;
            Q        <= '0;
            Rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd      <= R;
                        dvs      <= B;
                        prem     <= '0;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        if (B != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state    <= DONE;
                            Q        <= DIV0_Q;
                            Rem      <= '0;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd  <= {dvd[N_W-2:0], q_bit};
                    prem <= prem_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(N_W - 1)) begin
                        Q     <= {dvd[N_W-2:0], q_bit};
                        Rem   <= prem_next[D_W-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
